priority_scan_encoder: RTL and testbench

PRIORITY_SCAN_ENCODER -- requirements
Module: priority_scan_encoder

---
 rtl/priority_scan_encoder_pkg.sv | 11 +
 rtl/priority_scan_encoder_index.sv | 30 +++
 rtl/priority_scan_encoder.sv | 89 ++++++++
 tb/tb_priority_scan_encoder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/priority_scan_encoder_pkg.sv
// Shared definitions for the priority scan encoder: FSM state encoding and default width.
package priority_scan_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/priority_scan_encoder_index.sv
// Combinational priority index of a request vector, plus "any bit set" and "exactly one bit set".
module priority_index_n #(
    parameter int WIDTH     = priority_scan_encoder_pkg::DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             one_hot
);

    // Later loop iterations overwrite earlier ones, so the scan direction sets the winner.
    always_comb begin
        idx = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec_i[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec_i[i]) idx = IDX_W'(i);
            end
        end
    end

    assign any     = |vec_i;
    assign one_hot = any && ((vec_i & (vec_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_scan_encoder.sv
// Accepts a request vector and emits the index of every set bit, one per handshake, in priority order.
module priority_scan_encoder
    import priority_scan_encoder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_flag
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             zero_q, zero_d;

    logic [IDX_W-1:0] pri_idx;
    logic             pri_any;
    logic             pri_one;

    priority_index_n #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_index (
        .vec_i   (pending_q),
        .idx     (pri_idx),
        .any     (pri_any),
        .one_hot (pri_one)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Input and output phases never overlap: in_ready only in IDLE, out_valid only in SCAN.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_vec != '0) begin
                        pending_d = in_vec;
                        state_d   = SCAN;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                out_valid = 1'b1;
                out_idx   = pri_idx;
                out_last  = pri_one;
                if (out_ready) begin
                    pending_d = pending_q & ~(WIDTH'(1) << pri_idx);
                    // An empty register here is unreachable; leaving SCAN keeps it from sticking.
                    if (pri_one || !pri_any) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign zero_flag = zero_q;

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Directed bench for priority_scan_encoder: MSB-first and LSB-first instances on a shared clock/reset.
module tb_priority_scan_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_last, m_zero;
    logic [7:0] m_in_vec;
    logic [2:0] m_out_idx;

    logic       l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_out_last, l_zero;
    logic [7:0] l_in_vec;
    logic [2:0] l_out_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (m_in_valid),
        .in_ready  (m_in_ready),
        .in_vec    (m_in_vec),
        .out_valid (m_out_valid),
        .out_ready (m_out_ready),
        .out_idx   (m_out_idx),
        .out_last  (m_out_last),
        .zero_flag (m_zero)
    );

    priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (l_in_valid),
        .in_ready  (l_in_ready),
        .in_vec    (l_in_vec),
        .out_valid (l_out_valid),
        .out_ready (l_out_ready),
        .out_idx   (l_out_idx),
        .out_last  (l_out_last),
        .zero_flag (l_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_m_idle(input string tag);
        chk({tag, "_in_ready"}, m_in_ready, 1);
        chk({tag, "_out_valid"}, m_out_valid, 0);
        chk({tag, "_out_idx"}, m_out_idx, 0);
        chk({tag, "_out_last"}, m_out_last, 0);
    endtask

    task automatic chk_m_out(input string tag, input int idx, input bit last);
        chk({tag, "_valid"}, m_out_valid, 1);
        chk({tag, "_in_ready"}, m_in_ready, 0);
        chk({tag, "_idx"}, m_out_idx, idx);
        chk({tag, "_last"}, m_out_last, last);
    endtask

    task automatic send_m(input logic [7:0] v);
        m_in_vec   = v;
        m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0;
        m_in_vec   = 8'hA5;
    endtask

    initial begin
        int exp_lsb[4];
        int exp_alt[4];
        int exp_b2b[2];

        m_in_valid = 0; m_in_vec = 0; m_out_ready = 0;
        l_in_valid = 0; l_in_vec = 0; l_out_ready = 0;

        // Reset state, with an input offered that must not be taken while in reset.
        m_in_valid = 1; m_in_vec = 8'hFF;
        repeat (3) tick();
        chk_m_idle("reset");
        chk("reset_zero", m_zero, 0);
        chk("reset_l_in_ready", l_in_ready, 1);
        chk("reset_l_out_valid", l_out_valid, 0);
        m_in_valid = 0;
        rst_n = 1'b1;
        tick();
        chk_m_idle("post_release");

        // Two bits, MSB first, consumer always ready.
        m_out_ready = 1;
        send_m(8'b10001000);
        chk_m_out("v1_a", 7, 0);
        tick();
        chk_m_out("v1_b", 3, 1);
        tick();
        chk_m_idle("v1_done");

        // All ones: eight gapless handshakes.
        send_m(8'b11111111);
        for (int i = 0; i < 8; i++) begin
            chk_m_out($sformatf("ones_%0d", i), 7 - i, i == 7);
            tick();
        end
        chk_m_idle("ones_done");

        // LSB-first instance.
        exp_lsb = '{1, 2, 3, 5};
        l_out_ready = 1;
        l_in_vec = 8'b00101110;
        l_in_valid = 1;
        tick();
        l_in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lsb_%0d_valid", i), l_out_valid, 1);
            chk($sformatf("lsb_%0d_idx", i), l_out_idx, exp_lsb[i]);
            chk($sformatf("lsb_%0d_last", i), l_out_last, i == 3);
            tick();
        end
        chk("lsb_done_valid", l_out_valid, 0);
        chk("lsb_done_in_ready", l_in_ready, 1);

        // Backpressure: output must hold while out_ready is low.
        exp_alt = '{6, 4, 2, 0};
        m_out_ready = 0;
        send_m(8'b01010101);
        for (int i = 0; i < 4; i++) begin
            chk_m_out($sformatf("bp_%0d_pre", i), exp_alt[i], i == 3);
            m_out_ready = 0;
            tick();
            chk_m_out($sformatf("bp_%0d_hold", i), exp_alt[i], i == 3);
            m_out_ready = 1;
            tick();
        end
        chk_m_idle("bp_done");

        // Zero vector: one-cycle flag, no output.
        send_m(8'b00000000);
        chk("zero_flag_set", m_zero, 1);
        chk_m_idle("zero_accept");
        tick();
        chk("zero_flag_clear", m_zero, 0);
        chk_m_idle("zero_after");

        // Reset mid-scan discards the remaining bits.
        m_out_ready = 1;
        send_m(8'b11010000);
        chk_m_out("rst_first", 7, 0);
        tick();
        chk_m_out("rst_second", 6, 0);
        rst_n = 1'b0;
        #1;
        chk_m_idle("rst_async");
        chk("rst_async_zero", m_zero, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_m_idle("rst_released");
        tick();
        chk_m_idle("rst_no_leftover");

        exp_b2b = '{5, 1};
        send_m(8'b00100010);
        for (int i = 0; i < 2; i++) begin
            chk_m_out($sformatf("after_rst_%0d", i), exp_b2b[i], i == 1);
            tick();
        end
        chk_m_idle("after_rst_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
